bp_mem_traffic_gen: RTL and testbench

BP_MEM_TRAFFIC_GEN -- requirements
Module: bp_mem_traffic_gen

---
 rtl/bp_mem_traffic_gen.sv | 155 +++++++++++++++
 tb/tb_bp_mem_traffic_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_mem_traffic_gen.sv
// Memory traffic generator: writes a seeded pattern to num_words_p words, reads
// them back, and reports mismatches and response timeouts.
module bp_mem_traffic_gen #(
    parameter int                      addr_width_p = 40,
    parameter int                      data_width_p = 64,
    parameter int                      num_words_p  = 256,
    parameter logic [addr_width_p-1:0] base_addr_p  = 40'h80_0000_0000,
    parameter int                      timeout_p    = 1024,
    localparam int                     msg_width_lp = 2 + addr_width_p + data_width_p
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    start_i,
    input  logic [data_width_p-1:0] seed_i,
    output logic [msg_width_lp-1:0] mem_cmd_o,
    output logic                    mem_cmd_v_o,
    input  logic                    mem_cmd_ready_i,
    input  logic [msg_width_lp-1:0] mem_resp_i,
    input  logic                    mem_resp_v_i,
    output logic                    mem_resp_yumi_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic                    timeout_o,
    output logic [15:0]             error_count_o
);

    localparam int idx_w_lp   = (num_words_p > 1) ? $clog2(num_words_p) : 1;
    localparam int to_w_lp    = $clog2(timeout_p + 1);
    localparam int bytes_lp   = data_width_p / 8;
    localparam logic [1:0] op_rd_lp = 2'b00;
    localparam logic [1:0] op_wr_lp = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        WR_RESP,
        RD_CMD,
        RD_RESP,
        DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [idx_w_lp-1:0]       idx_q, idx_d;
    logic [data_width_p-1:0]   seed_q, seed_d;
    logic [15:0]               err_q, err_d;
    logic [to_w_lp-1:0]        to_cnt_q, to_cnt_d;
    logic                      timeout_q, timeout_d;

    logic [addr_width_p-1:0]   exp_addr;
    logic [data_width_p-1:0]   exp_pat;
    logic [1:0]                resp_op;
    logic [addr_width_p-1:0]   resp_addr;
    logic [data_width_p-1:0]   resp_data;
    logic                      resp_bad;
    logic                      last_word;
    logic [to_w_lp-1:0]        to_inc;

    assign exp_addr  = base_addr_p + addr_width_p'(idx_q) * addr_width_p'(bytes_lp);
    assign exp_pat   = seed_q ^ data_width_p'(idx_q);
    assign resp_op   = mem_resp_i[1:0];
    assign resp_addr = mem_resp_i[addr_width_p+1:2];
    assign resp_data = mem_resp_i[msg_width_lp-1:addr_width_p+2];
    assign last_word = (idx_q == idx_w_lp'(num_words_p - 1));
    assign to_inc    = to_cnt_q + to_w_lp'(1);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        seed_d          = seed_q;
        err_d           = err_q;
        to_cnt_d        = to_cnt_q;
        timeout_d       = timeout_q;
        mem_cmd_o       = '0;
        mem_cmd_v_o     = 1'b0;
        mem_resp_yumi_o = 1'b0;
        resp_bad        = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    seed_d    = seed_i;
                    idx_d     = '0;
                    err_d     = '0;
                    to_cnt_d  = '0;
                    timeout_d = 1'b0;
                    state_d   = WR_CMD;
                end
            end
            WR_CMD, RD_CMD: begin
                mem_cmd_v_o = 1'b1;
                mem_cmd_o   = (state_q == WR_CMD) ? {exp_pat, exp_addr, op_wr_lp}
                                                  : {{data_width_p{1'b0}}, exp_addr, op_rd_lp};
                if (mem_cmd_ready_i) begin
                    to_cnt_d = '0;
                    state_d  = (state_q == WR_CMD) ? WR_RESP : RD_RESP;
                end
            end
            WR_RESP, RD_RESP: begin
                mem_resp_yumi_o = mem_resp_v_i;
                if (mem_resp_v_i) begin
                    if (state_q == WR_RESP) begin
                        resp_bad = (resp_op != op_wr_lp) || (resp_addr != exp_addr);
                    end else begin
                        resp_bad = (resp_op != op_rd_lp) || (resp_addr != exp_addr)
                                   || (resp_data != exp_pat);
                    end
                    if (resp_bad && (err_q != 16'hFFFF)) begin
                        err_d = err_q + 16'd1;
                    end
                    if (!last_word) begin
                        idx_d   = idx_q + idx_w_lp'(1);
                        state_d = (state_q == WR_RESP) ? WR_CMD : RD_CMD;
                    end else if (state_q == WR_RESP) begin
                        idx_d   = '0;
                        state_d = RD_CMD;
                    end else begin
                        state_d = DONE;
                    end
                end else if (to_inc == to_w_lp'(timeout_p)) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    to_cnt_d = to_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            seed_q    <= '0;
            err_q     <= '0;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            seed_q    <= seed_d;
            err_q     <= err_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign done_o        = (state_q == DONE);
    assign timeout_o     = timeout_q;
    assign error_count_o = err_q;
    assign pass_o        = done_o & (err_q == 16'd0) & ~timeout_q;

endmodule

// File: tb/tb_bp_mem_traffic_gen.sv
// Directed bench for bp_mem_traffic_gen with a one-cycle-latency memory responder.
module tb_bp_mem_traffic_gen;

    localparam int AW = 40;
    localparam int DW = 64;
    localparam int NW = 4;
    localparam int TO = 8;
    localparam int MW = 2 + AW + DW;
    localparam logic [AW-1:0] BASE = 40'h80_0000_0000;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          start  = 1'b0;
    logic [DW-1:0] seed   = '0;
    logic          ready  = 1'b1;
    logic [MW-1:0] resp   = '0;
    logic          resp_v = 1'b0;
    logic [MW-1:0] cmd;
    logic          cmd_v, yumi, done, pass, tmo;
    logic [15:0]   errc;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    bp_mem_traffic_gen #(
        .addr_width_p(AW), .data_width_p(DW), .num_words_p(NW),
        .base_addr_p(BASE), .timeout_p(TO)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .seed_i(seed),
        .mem_cmd_o(cmd), .mem_cmd_v_o(cmd_v), .mem_cmd_ready_i(ready),
        .mem_resp_i(resp), .mem_resp_v_i(resp_v), .mem_resp_yumi_o(yumi),
        .done_o(done), .pass_o(pass), .timeout_o(tmo), .error_count_o(errc)
    );

    // Memory responder state
    logic [DW-1:0] mem [0:7];
    logic [AW-1:0] wr_addr_log [$];
    int            n_cmds = 0;
    int            n_rd   = 0;
    bit            drop_next_write = 1'b0;
    int            corrupt_word = -1;

    initial begin : responder
        logic          acc, cons;
        logic [MW-1:0] c;
        int            w;
        forever begin
            @(negedge clk);
            acc  = cmd_v & ready;
            cons = yumi;
            c    = cmd;
            @(posedge clk); #1;
            if (!rst_n) begin
                resp_v = 1'b0;
            end else begin
                if (cons) resp_v = 1'b0;
                if (acc) begin
                    n_cmds++;
                    w = int'((c[AW+1:2] - BASE) >> 3) & 7;
                    if (c[1:0] == 2'b01) begin
                        wr_addr_log.push_back(c[AW+1:2]);
                        mem[w] = c[MW-1:AW+2];
                        if (drop_next_write) begin
                            drop_next_write = 1'b0;
                        end else begin
                            resp   = {{DW{1'b0}}, c[AW+1:2], 2'b01};
                            resp_v = 1'b1;
                        end
                    end else begin
                        n_rd++;
                        resp   = {mem[w] ^ ((w == corrupt_word) ? 64'h1 : 64'h0), c[AW+1:2], 2'b00};
                        resp_v = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic clear_logs();
        wr_addr_log.delete();
        n_cmds = 0;
        n_rd   = 0;
    endtask

    task automatic start_run(input logic [DW-1:0] s);
        clear_logs();
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    initial begin : stimulus
        int  cyc;
        bit  stable;
        logic [MW-1:0] exp_cmd;

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        check("rst_done",    done,   0);
        check("rst_pass",    pass,   0);
        check("rst_timeout", tmo,    0);
        check("rst_errc",    errc,   0);
        check("rst_cmd_v",   cmd_v,  0);
        check("rst_cmd",     cmd,    0);
        check("rst_yumi",    yumi,   0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("idle_no_cmd", {done, cmd_v}, 2'b00);

        // Clean pass with ideal memory
        start_run(64'h1111);
        check("a_first_cmd", cmd, {64'h1111, 40'h80_0000_0000, 2'b01});
        run_until_done(cyc);
        check("a_done_latency", cyc, 16);
        check("a_pass",    pass, 1);
        check("a_errc",    errc, 0);
        check("a_timeout", tmo,  0);
        check("a_n_cmds",  n_cmds, 8);
        check("a_n_rd",    n_rd,   4);
        check("a_n_wr",    wr_addr_log.size(), 4);
        if (wr_addr_log.size() == 4) begin
            check("a_wr_addr0", wr_addr_log[0], 40'h80_0000_0000);
            check("a_wr_addr1", wr_addr_log[1], 40'h80_0000_0008);
            check("a_wr_addr2", wr_addr_log[2], 40'h80_0000_0010);
            check("a_wr_addr3", wr_addr_log[3], 40'h80_0000_0018);
        end
        check("a_mem3_pat", mem[3], 64'h1112);

        // Corrupted read of word 2, with start held into WR_CMD
        corrupt_word = 2;
        clear_logs();
        seed  = 64'hA5A5;
        start = 1'b1;
        tick();
        seed  = 64'hFFFF;
        check("b_first_cmd", cmd, {64'hA5A5, 40'h80_0000_0000, 2'b01});
        tick();
        start = 1'b0;
        check("b_start_ignored", {yumi, cmd_v}, 2'b10);
        run_until_done(cyc);
        check("b_done",   done, 1);
        check("b_errc",   errc, 1);
        check("b_pass",   pass, 0);
        check("b_n_cmds", n_cmds, 8);
        check("b_mem1_pat", mem[1], 64'hA5A4);
        corrupt_word = -1;

        // Back-pressure on the first command; also a fresh error count from DONE
        ready = 1'b0;
        start_run(64'h5);
        check("c_errc_fresh", errc, 0);
        exp_cmd = {64'h5, 40'h80_0000_0000, 2'b01};
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(cmd_v === 1'b1 && cmd === exp_cmd)) stable = 1'b0;
            tick();
        end
        check("c_cmd_stable", stable, 1);
        check("c_no_accept",  n_cmds, 0);
        ready = 1'b1;
        run_until_done(cyc);
        check("c_pass",   pass, 1);
        check("c_n_cmds", n_cmds, 8);
        check("c_wr0_once", wr_addr_log[0], 40'h80_0000_0000);

        // No response to the first write
        drop_next_write = 1'b1;
        start_run(64'h0);
        run_until_done(cyc);
        check("d_timeout_latency", cyc, 9);
        check("d_done",    done, 1);
        check("d_timeout", tmo,  1);
        check("d_pass",    pass, 0);
        check("d_n_cmds",  n_cmds, 1);

        // Reset during RD_RESP, then a clean rerun
        start_run(64'h77);
        for (int i = 0; i < 9; i++) tick();
        check("e_in_rd_resp", {yumi, cmd_v}, 2'b10);
        rst_n = 1'b0;
        #1;
        check("e_rst_outs", {done, pass, tmo, errc, cmd_v, yumi}, 0);
        check("e_rst_cmd",  cmd, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("e_idle_after_rst", {done, cmd_v}, 2'b00);
        start_run(64'h77);
        run_until_done(cyc);
        check("e_done_latency", cyc, 16);
        check("e_pass",   pass, 1);
        check("e_errc",   errc, 0);
        check("e_n_cmds", n_cmds, 8);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
